light_int_filter: RTL and testbench
===================================

Name: light_int_filter

Overview:
Conditioning stage directly upstream of the light-sensor interrupt PIO. Takes the raw active-low open-drain INT pin from the ambient-light sensor and synchronises and debounces it with a programmable qualification time. Drives a clean active-high level into the PIO's in_port, so the PIO's rising-edge capture fires exactly once per real sensor event. Also exposes a small Avalon-MM slave for configuration, status and a saturating event counter.

Parameters:
DEFAULT_DEBOUNCE, 500, reset value of the DEBOUNCE register in clk cycles (10 us at 50 MHz)
CNT_W, 16, width of the debounce counter, the DEBOUNCE field and the EVENT_COUNT field
MIN_HOLD, 50000, minimum int_out high time in cycles; used only with LIGHT_INT_MIN_HOLD_EN

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
sensor_int_n  in  1  raw sensor interrupt, active-low, asynchronous to clk
address  in  2  Avalon word address
chipselect  in  1  Avalon select
write_n  in  1  Avalon write strobe, active-low
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, registered
int_out  out  1  filtered interrupt level, active-high, to PIO in_port

Behaviour:
- Reset is asynchronous, active-low (reset_n); clock is clk.
- Reset values:
  - readdata=0, int_out=0, FSM=IDLE, debounce counter=0.
  - Synchroniser flops=1 (deasserted).
  - DEBOUNCE=DEFAULT_DEBOUNCE, EVENT_COUNT=0, CONTROL.enable=1.
- Synchroniser: 2-FF on sensor_int_n. sync_int = NOT second flop.
- Register map (writes take effect when chipselect & ~write_n):
  - 0 STATUS, RO: [0] int_out, [1] sync_int, [3:2] FSM state encoding (IDLE=0, QUAL_ASSERT=1, ASSERTED=2, QUAL_DEASSERT=3).
  - 1 DEBOUNCE, RW: [CNT_W-1:0].
  - 2 EVENT_COUNT: read returns [CNT_W-1:0]; a write of any data clears it.
  - 3 CONTROL, RW: [0] enable.
  - Unused bits read 0.
- readdata updates every clk from the address mux, independent of chipselect. Read latency is 1 cycle.
- FSM, evaluated each clk while enable=1:
  - IDLE: if sync_int, cnt<=DEBOUNCE and go to QUAL_ASSERT.
  - QUAL_ASSERT:
    - if !sync_int, go to IDLE;
    - else if cnt==0, go to ASSERTED, set int_out<=1, EVENT_COUNT++;
    - else cnt--.
  - ASSERTED: if !sync_int, cnt<=DEBOUNCE and go to QUAL_DEASSERT.
  - QUAL_DEASSERT:
    - if sync_int, go to ASSERTED (int_out stays 1, no count);
    - else if cnt==0, go to IDLE, set int_out<=0;
    - else cnt--.
- Latency with sensor_int_n held low: int_out rises on edge DEBOUNCE+4, counting the first edge that samples it low. The fall is symmetric.
- Glitches: any low pulse shorter than DEBOUNCE+1 synchronised cycles produces no int_out edge and no count.
- DEBOUNCE=0: qualification takes a single cycle in QUAL state.
- DEBOUNCE written mid-qualification: the running cnt is unaffected; the new value applies at the next load.
- EVENT_COUNT saturates at all-ones and never wraps.
- Clear write and qualifying event in the same cycle: the event wins after the clear, so EVENT_COUNT=1.
- enable=0: FSM forced to IDLE and int_out<=0 on the next edge, including mid-ASSERTED. EVENT_COUNT is held. The synchroniser keeps running.
- Re-enable with the pin already low: qualification restarts from IDLE, and a new event is counted.
- sensor_int_n is never used unsynchronised.

Optional Feature:
LIGHT_INT_MIN_HOLD_EN
- Defined:
  - A hold counter loads MIN_HOLD-1 on entry to ASSERTED and decrements each cycle.
  - ASSERTED may only leave toward QUAL_DEASSERT once the hold counter is 0.
  - int_out therefore stays high at least MIN_HOLD cycles.
  - enable=0 still forces IDLE immediately.
- Undefined: the hold counter is absent, and ASSERTED exits as soon as !sync_int.

Test Plan:
- Reset, then read addr 0,1,2,3 -> readdata 0x0, DEFAULT_DEBOUNCE (0x1F4), 0x0, 0x1, each valid 1 cycle after address.
- DEBOUNCE=10; hold sensor_int_n low 100 cycles -> int_out rises on edge 14; EVENT_COUNT=1; release -> int_out falls 14 edges after release.
- DEBOUNCE=10; low pulse of 8 cycles, then high -> int_out stays 0, EVENT_COUNT stays 0. During the pulse, STATUS[3:2] goes 1 then 0.
- DEBOUNCE=0; during ASSERTED, write CONTROL=0 -> int_out=0 the next cycle, STATUS[3:2]=0. Write CONTROL=1 with the pin still low -> int_out rises 2 cycles later; EVENT_COUNT increments.
- Preload EVENT_COUNT to 0xFFFF via 65535 events (DEBOUNCE=0) -> one more event leaves 0xFFFF. A clear write on the same cycle as a qualifying event -> reads 0x1.
- With LIGHT_INT_MIN_HOLD_EN, MIN_HOLD=20, DEBOUNCE=0; 5-cycle low pulse -> int_out high exactly 20 cycles, then the deassert qualification; one count.

Source files
------------

// File: rtl/light_int_filter.sv
// Synchronises and debounces the active-low light-sensor INT pin into a clean active-high level.
// Optional minimum high time on int_out is enabled by defining LIGHT_INT_MIN_HOLD_EN.
module light_int_filter #(
  parameter int unsigned DEFAULT_DEBOUNCE = 500,
  parameter int unsigned CNT_W            = 16,
  parameter int unsigned MIN_HOLD         = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sensor_int_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        int_out
);

  localparam logic [1:0] StIdle         = 2'd0;
  localparam logic [1:0] StQualAssert   = 2'd1;
  localparam logic [1:0] StAsserted     = 2'd2;
  localparam logic [1:0] StQualDeassert = 2'd3;

  logic             sync1_q, sync2_q;
  logic             sync_int;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             int_q, int_d;
  logic [CNT_W-1:0] debounce_q, debounce_d;
  logic [CNT_W-1:0] evt_q, evt_d;
  logic             enable_q, enable_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             evt_inc;
  logic             wr_en;
  logic             hold_done;
  logic             unused_wdata;

  assign sync_int     = ~sync2_q;
  assign wr_en        = chipselect & ~write_n;
  assign int_out      = int_q;
  assign readdata     = rdata_q;
  assign unused_wdata = ^writedata;

  // Flops reset to 1 so a reset never looks like an asserted pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= sensor_int_n;
      sync2_q <= sync1_q;
    end
  end

`ifdef LIGHT_INT_MIN_HOLD_EN
  localparam int unsigned HOLD_W = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;

  logic [HOLD_W-1:0] hold_q, hold_d;

  assign hold_done = (hold_q == '0);

  always_comb begin
    hold_d = hold_q;
    if (state_d == StAsserted && state_q != StAsserted) begin
      hold_d = HOLD_W'(MIN_HOLD - 1);
    end else if (hold_q != '0) begin
      hold_d = hold_q - HOLD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign hold_done = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    int_d   = int_q;
    evt_inc = 1'b0;
    if (!enable_q) begin
      state_d = StIdle;
      int_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (sync_int) begin
            cnt_d   = debounce_q;
            state_d = StQualAssert;
          end
        end
        StQualAssert: begin
          if (!sync_int) begin
            state_d = StIdle;
          end else if (cnt_q == '0) begin
            state_d = StAsserted;
            int_d   = 1'b1;
            evt_inc = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        StAsserted: begin
          if (!sync_int && hold_done) begin
            cnt_d   = debounce_q;
            state_d = StQualDeassert;
          end
        end
        StQualDeassert: begin
          if (sync_int) begin
            state_d = StAsserted;
          end else if (cnt_q == '0) begin
            state_d = StIdle;
            int_d   = 1'b0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    debounce_d = debounce_q;
    enable_d   = enable_q;
    evt_d      = evt_q;
    if (wr_en && address == 2'd1) debounce_d = writedata[CNT_W-1:0];
    if (wr_en && address == 2'd3) enable_d = writedata[0];
    if (wr_en && address == 2'd2) evt_d = '0;
    // The clear is applied first so a coincident event still lands as a count of one.
    if (evt_inc && evt_d != '1) evt_d = evt_d + CNT_W'(1);
  end

  always_comb begin
    rdata_d = '0;
    case (address)
      2'd0: rdata_d = {28'd0, state_q, sync_int, int_q};
      2'd1: rdata_d = 32'(debounce_q);
      2'd2: rdata_d = 32'(evt_q);
      2'd3: rdata_d = {31'd0, enable_q};
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      int_q      <= 1'b0;
      debounce_q <= CNT_W'(DEFAULT_DEBOUNCE);
      evt_q      <= '0;
      enable_q   <= 1'b1;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      int_q      <= int_d;
      debounce_q <= debounce_d;
      evt_q      <= evt_d;
      enable_q   <= enable_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_light_int_filter.sv
// Self-checking bench for light_int_filter: register table, directed corner sequences and a
// randomized pin stream compared against a run-length reference model.
module tb_light_int_filter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pin, s_pin;
  logic [1:0]  address;
  logic        cs, s_cs, write_n;
  logic [31:0] writedata;
  logic [31:0] rdata, s_rdata;
  logic        int_out, s_int_out;
  int          total = 0;
  int          bad   = 0;

  typedef struct {
    bit          sel;
    logic [1:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;

  always #5 clk = ~clk;

  light_int_filter #(
    .DEFAULT_DEBOUNCE(500),
    .CNT_W           (16),
    .MIN_HOLD        (20)
  ) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sensor_int_n(pin),
    .address     (address),
    .chipselect  (cs),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (rdata),
    .int_out     (int_out)
  );

  // Narrow instance so counter saturation is reachable in few events.
  light_int_filter #(
    .DEFAULT_DEBOUNCE(0),
    .CNT_W           (4),
    .MIN_HOLD        (1)
  ) u_sat (
    .clk         (clk),
    .reset_n     (reset_n),
    .sensor_int_n(s_pin),
    .address     (address),
    .chipselect  (s_cs),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (s_rdata),
    .int_out     (s_int_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // All bus tasks are entered at a negedge and return at a negedge.
  task automatic bus_write(input bit sel, input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    cs        = ~sel;
    s_cs      = sel;
    @(negedge clk);
    write_n = 1'b1;
    cs      = 1'b0;
    s_cs    = 1'b0;
  endtask

  task automatic bus_read(input bit sel, input logic [1:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = sel ? s_rdata : rdata;
  endtask

  task automatic wait_level(input logic val, input int bound, output int k);
    k = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (int_out == val) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic pulse_sat();
    s_pin = 1'b0;
    repeat (3) @(negedge clk);
    s_pin = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    rd_vec_t     vecs [6];
    logic [31:0] rd;
    int          k, kr, kf;
    logic        saw_qual, saw_other, int_seen;
    int          d, run_len, run, m_cnt;
    logic        m_int, m_s1, m_s2, s;

    vecs[0] = '{sel: 1'b0, addr: 2'd0, exp: 32'h0};
    vecs[1] = '{sel: 1'b0, addr: 2'd1, exp: 32'h1F4};
    vecs[2] = '{sel: 1'b0, addr: 2'd2, exp: 32'h0};
    vecs[3] = '{sel: 1'b0, addr: 2'd3, exp: 32'h1};
    vecs[4] = '{sel: 1'b1, addr: 2'd1, exp: 32'h0};
    vecs[5] = '{sel: 1'b1, addr: 2'd3, exp: 32'h1};

    reset_n   = 1'b0;
    pin       = 1'b1;
    s_pin     = 1'b1;
    address   = 2'd0;
    cs        = 1'b0;
    s_cs      = 1'b0;
    write_n   = 1'b1;
    writedata = '0;
    repeat (2) @(negedge clk);
    check("reset_readdata", rdata, 32'h0);
    check("reset_int_out", 32'(int_out), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      bus_read(vecs[i].sel, vecs[i].addr, rd);
      check($sformatf("reset_reg%0d", i), rd, vecs[i].exp);
    end

    // Held low with DEBOUNCE=10: rise and fall both on edge 14.
    bus_write(1'b0, 2'd1, 32'd10);
    pin = 1'b0;
    wait_level(1'b1, 40, k);
    check("rise_edge_d10", 32'(k), 32'd14);
    repeat (80) @(negedge clk);
    bus_read(1'b0, 2'd2, rd);
    check("event_count_1", rd, 32'd1);
    pin = 1'b1;
    wait_level(1'b0, 40, k);
    check("fall_edge_d10", 32'(k), 32'd14);

    // 8-cycle glitch with DEBOUNCE=10: qualifies briefly, never asserts.
    repeat (4) @(negedge clk);
    address   = 2'd0;
    saw_qual  = 1'b0;
    saw_other = 1'b0;
    int_seen  = 1'b0;
    pin       = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (i == 8) pin = 1'b1;
      if (rdata[3:2] == 2'd1) saw_qual = 1'b1;
      if (rdata[3:2] >= 2'd2) saw_other = 1'b1;
      if (int_out) int_seen = 1'b1;
    end
    check("glitch_saw_qual", 32'(saw_qual), 32'd1);
    check("glitch_no_assert_state", 32'(saw_other), 32'd0);
    check("glitch_int_out", 32'(int_seen), 32'd0);
    check("glitch_final_state", 32'(rdata[3:2]), 32'd0);
    bus_read(1'b0, 2'd2, rd);
    check("glitch_count", rd, 32'd1);

    // DEBOUNCE=0, disable mid-ASSERTED, then re-enable with pin still low.
    bus_write(1'b0, 2'd1, 32'd0);
    pin = 1'b0;
    wait_level(1'b1, 20, k);
    check("rise_edge_d0", 32'(k), 32'd4);
    repeat (3) @(negedge clk);
    bus_write(1'b0, 2'd3, 32'd0);
    @(negedge clk);
    check("disable_int_out", 32'(int_out), 32'd0);
    bus_read(1'b0, 2'd0, rd);
    check("disable_status", rd, 32'h2);
    bus_read(1'b0, 2'd2, rd);
    check("count_held", rd, 32'd2);
    bus_write(1'b0, 2'd3, 32'd1);
    @(negedge clk);
    check("reenable_wait", 32'(int_out), 32'd0);
    @(negedge clk);
    check("reenable_rise", 32'(int_out), 32'd1);
    bus_read(1'b0, 2'd2, rd);
    check("count_reenable", rd, 32'd3);
    pin = 1'b1;
    wait_level(1'b0, 60, k);
`ifdef LIGHT_INT_MIN_HOLD_EN
    check("fall_seen", 32'(k > 0), 32'd1);

    // 5-cycle pulse: 20 cycles of hold plus one cycle of deassert qualification.
    repeat (2) @(negedge clk);
    pin = 1'b0;
    kr  = -1;
    kf  = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 5) pin = 1'b1;
      if (int_out && kr < 0) kr = i;
      if (!int_out && kr > 0 && kf < 0) kf = i;
    end
    check("hold_rise", 32'(kr), 32'd4);
    check("hold_width", 32'(kf - kr), 32'd21);
    bus_read(1'b0, 2'd2, rd);
    check("hold_count", rd, 32'd4);
`else
    check("fall_edge_d0", 32'(k), 32'd4);
`endif

    // Saturation on the 4-bit instance.
    for (int i = 0; i < 15; i++) pulse_sat();
    bus_read(1'b1, 2'd2, rd);
    check("sat_count_15", rd, 32'hF);
    pulse_sat();
    bus_read(1'b1, 2'd2, rd);
    check("sat_hold_max", rd, 32'hF);
    bus_write(1'b1, 2'd2, 32'd0);
    bus_read(1'b1, 2'd2, rd);
    check("sat_clear", rd, 32'h0);
    pulse_sat();
    // Clear lands on the same edge as the qualifying event (edge 4 with DEBOUNCE=0).
    s_pin = 1'b0;
    repeat (3) @(negedge clk);
    bus_write(1'b1, 2'd2, 32'hDEAD);
    check("clr_evt_int", 32'(s_int_out), 32'd1);
    bus_read(1'b1, 2'd2, rd);
    check("clr_evt_count", rd, 32'h1);
    s_pin = 1'b1;
    repeat (6) @(negedge clk);

`ifndef LIGHT_INT_MIN_HOLD_EN
    // Model: int_out flips once sync_int has disagreed with it for DEBOUNCE+2 straight edges.
    for (int r = 0; r < 2; r++) begin
      pin     = 1'b1;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      d = $urandom_range(0, 4);
      bus_write(1'b0, 2'd1, 32'(d));
      m_int   = 1'b0;
      m_s1    = 1'b1;
      m_s2    = 1'b1;
      run     = 0;
      m_cnt   = 0;
      run_len = 0;
      for (int c = 0; c < 1500; c++) begin
        check("rand_int_out", 32'(int_out), 32'(m_int));
        if (c >= 1480) begin
          pin = 1'b1;
        end else begin
          if (run_len == 0) begin
            pin     = ~pin;
            run_len = $urandom_range(1, d + 5);
          end
          run_len--;
        end
        @(posedge clk);
        s    = ~m_s2;
        m_s2 = m_s1;
        m_s1 = pin;
        if (s != m_int) begin
          run++;
          if (run == d + 2) begin
            m_int = ~m_int;
            run   = 0;
            if (m_int) m_cnt++;
          end
        end else begin
          run = 0;
        end
        @(negedge clk);
      end
      bus_read(1'b0, 2'd2, rd);
      check("rand_event_count", rd, 32'(m_cnt));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
